// File: rtl/pla_seq_pkg.sv
// Shared types and constants for the PLA vector sequencer: FSM states,
// LFSR/MISR tap positions and the MISR initial value.
package pla_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int LFSR_W = 27;
  localparam int LFSR_TAP_A = 27;
  localparam int LFSR_TAP_B = 5;
  localparam int LFSR_TAP_C = 2;
  localparam int LFSR_TAP_D = 1;

  // Tap positions are 1-based polynomial exponents; masks select the bits.
  localparam logic [LFSR_W-1:0] LFSR_MASK =
      (LFSR_W'(1) << (LFSR_TAP_A - 1)) | (LFSR_W'(1) << (LFSR_TAP_B - 1)) |
      (LFSR_W'(1) << (LFSR_TAP_C - 1)) | (LFSR_W'(1) << (LFSR_TAP_D - 1));

  localparam int MISR_TAP_A = 16;
  localparam int MISR_TAP_B = 15;
  localparam int MISR_TAP_C = 13;
  localparam int MISR_TAP_D = 4;

  localparam logic [15:0] MISR_MASK =
      (16'(1) << (MISR_TAP_A - 1)) | (16'(1) << (MISR_TAP_B - 1)) |
      (16'(1) << (MISR_TAP_C - 1)) | (16'(1) << (MISR_TAP_D - 1));

  localparam logic [15:0] MISR_INIT = 16'hFFFF;

endpackage

// File: rtl/pla_misr16.sv
// 16-bit multiple-input signature register; init has priority over enable.
module pla_misr16
  import pla_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [15:0] data,
  output logic [15:0] sig
);

  logic fb;

  assign fb = ^(sig & MISR_MASK);

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= MISR_INIT;
    end else if (init) begin
      sig <= MISR_INIT;
    end else if (en) begin
      sig <= {sig[14:0], fb} ^ data;
    end
  end

endmodule

// File: rtl/pla_vec_sequencer.sv
// LFSR stimulus generator and MISR/toggle response checker wrapped around a
// combinational PLA benchmark; one vector every SETTLE+2 cycles.
module pla_vec_sequencer
  import pla_seq_pkg::*;
#(
  parameter int IN_W   = 27,
  parameter int OUT_W  = 6,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [IN_W-1:0]  seed,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [15:0]      signature,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] vec_cnt
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

  state_t            state, state_nxt;
  logic [SET_W-1:0]  settle_cnt;
  logic [CNT_W-1:0]  num_vec_q;
  logic [OUT_W-1:0]  prev_out;
  logic              accept, sample, last_vec;
  logic [IN_W-1:0]   seed_eff, lfsr_nxt;
  logic [SUM_W-1:0]  tog_sum;
  logic [CNT_W-1:0]  tog_sat;

  assign seed_eff = (seed == '0) ? IN_W'(1) : seed;
  assign lfsr_nxt = {dut_in[IN_W-2:0], ^(dut_in & LFSR_MASK)};
  assign last_vec = (vec_cnt + 1'b1) == num_vec_q;

  // The first sample of a run has no predecessor, so it adds no toggles.
  assign tog_sum = {1'b0, toggle_cnt} +
                   ((vec_cnt == '0) ? '0 : SUM_W'($countones(dut_out ^ prev_out)));
  assign tog_sat = tog_sum[CNT_W] ? '1 : tog_sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: defaults first so every path assigns every output and no latch forms.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sample    = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (num_vec == '0) ? ST_DONE : ST_APPLY;
        end
      end
      ST_APPLY:  state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = ST_SAMPLE;
      ST_SAMPLE: begin
        sample    = 1'b1;
        state_nxt = last_vec ? ST_DONE : ST_APPLY;
      end
      default:   state_nxt = ST_IDLE;
    endcase
    // Abort freezes the datapath and overrides any transition.
    if (abort) begin
      state_nxt = ST_IDLE;
      accept    = 1'b0;
      sample    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_in     <= '0;
      num_vec_q  <= '0;
      vec_cnt    <= '0;
      toggle_cnt <= '0;
      prev_out   <= '0;
      settle_cnt <= '0;
    end else begin
      settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
      if (accept) begin
        num_vec_q  <= num_vec;
        vec_cnt    <= '0;
        toggle_cnt <= '0;
        if (num_vec != '0) dut_in <= seed_eff;
      end
      if (sample) begin
        vec_cnt    <= vec_cnt + 1'b1;
        toggle_cnt <= tog_sat;
        prev_out   <= dut_out;
        if (!last_vec) dut_in <= lfsr_nxt;
      end
    end
  end

  pla_misr16 u_misr (
    .clk  (clk),
    .rst  (rst),
    .init (accept),
    .en   (sample),
    .data (16'(dut_out)),
    .sig  (signature)
  );

  assign busy = (state == ST_APPLY) || (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_pla_vec_sequencer.sv
// Scoreboard bench: stimulus queues expected vectors and run results, a
// negedge monitor pops and compares them as the sequencer presents them.
module tb_pla_vec_sequencer;

  localparam int IN_W  = 27;
  localparam int OUT_W = 6;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, abort;
  logic [CNT_W-1:0] num_vec;
  logic [IN_W-1:0]  seed;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic             busy, done;
  logic [15:0]      signature;
  logic [CNT_W-1:0] toggle_cnt, vec_cnt;

  pla_vec_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .SETTLE(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .num_vec    (num_vec),
    .seed       (seed),
    .dut_in     (dut_in),
    .dut_out    (dut_out),
    .busy       (busy),
    .done       (done),
    .signature  (signature),
    .toggle_cnt (toggle_cnt),
    .vec_cnt    (vec_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] sig;
    int          tog;
    int          vcnt;
    int          lat;
  } exp_t;

  exp_t            exp_q[$];
  logic [IN_W-1:0] din_q[$];
  int              checks = 0;
  int              failures = 0;
  int              start_cyc = 0;
  bit              alt_mode = 1'b0;
  int              vec_idx = 0;

  // Stand-in benchmark: 3F/00 alternating per vector in alt mode, else 0.
  assign dut_out = (alt_mode && (vec_idx[0] == 1'b0)) ? 6'h3F : 6'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic            busy_q = 1'b0, done_q = 1'b0;
  logic [IN_W-1:0] din_prev = '0;
  exp_t            mon_e;
  logic [IN_W-1:0] mon_din;

  always @(negedge clk) begin
    if (!rst) begin
      if (busy && (!busy_q || dut_in != din_prev)) begin
        vec_idx = busy_q ? vec_idx + 1 : 0;
        if (din_q.size() == 0) begin
          check("extra_vector", din_q.size(), 1);
        end else begin
          mon_din = din_q.pop_front();
          check("dut_in", dut_in, mon_din);
        end
      end
      if (done && !done_q) begin
        if (exp_q.size() == 0) begin
          check("extra_done", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("signature", signature, mon_e.sig);
          check("toggle_cnt", toggle_cnt, mon_e.tog);
          check("vec_cnt", vec_cnt, mon_e.vcnt);
          check("done_latency", cyc - start_cyc, mon_e.lat);
        end
      end
    end
    busy_q   = busy;
    done_q   = done;
    din_prev = dut_in;
  end

  task automatic launch(input int n, input logic [IN_W-1:0] s);
    @(posedge clk); #1;
    num_vec   = CNT_W'(n);
    seed      = s;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit saw_busy);
    bit got;
    got = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
      if (done) got = 1'b1;
    end
    check("done_within_budget", got, 1);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dut_in"}, dut_in, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_signature"}, signature, 16'hFFFF);
    check({tag, "_toggle_cnt"}, toggle_cnt, 0);
    check({tag, "_vec_cnt"}, vec_cnt, 0);
  endtask

  bit sb;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; num_vec = '0; seed = '0;
    cycles(3);
    check_reset_values("reset");
    rst = 1'b0;
    cycles(2);

    // Seed 1, three vectors, quiet outputs.
    din_q.push_back(27'h1); din_q.push_back(27'h3); din_q.push_back(27'h6);
    exp_q.push_back('{sig: 16'hFFF8, tog: 0, vcnt: 3, lat: 13});
    launch(3, 27'h1);
    wait_done(40, sb);

    // Single vector restarted straight from DONE.
    din_q.push_back(27'h1);
    exp_q.push_back('{sig: 16'hFFFE, tog: 0, vcnt: 1, lat: 5});
    launch(1, 27'h1);
    wait_done(20, sb);

    // Abort out of DONE: done drops, results hold.
    abort = 1'b1;
    cycles(1);
    abort = 1'b0;
    check("abort_done_done", done, 0);
    check("abort_done_busy", busy, 0);
    check("abort_done_sig_hold", signature, 16'hFFFE);
    check("abort_done_vec_hold", vec_cnt, 1);

    // Zero-length run.
    exp_q.push_back('{sig: 16'hFFFF, tog: 0, vcnt: 0, lat: 1});
    launch(0, 27'h5);
    wait_done(10, sb);
    check("n0_busy_never_high", sb, 0);

    // Alternating outputs: toggles 0+6+6+6.
    alt_mode = 1'b1;
    din_q.push_back(27'h1); din_q.push_back(27'h3);
    din_q.push_back(27'h6); din_q.push_back(27'hD);
    exp_q.push_back('{sig: 16'hFE70, tog: 18, vcnt: 4, lat: 17});
    launch(4, 27'h1);
    wait_done(40, sb);
    alt_mode = 1'b0;

    // Seed 0 maps to 1; a start pulse mid-run is ignored.
    din_q.push_back(27'h1); din_q.push_back(27'h3);
    exp_q.push_back('{sig: 16'hFFFC, tog: 0, vcnt: 2, lat: 9});
    launch(2, 27'h0);
    cycles(2);
    num_vec = CNT_W'(7); seed = 27'h5; start = 1'b1;
    cycles(1);
    start = 1'b0;
    wait_done(30, sb);

    // Abort in SETTLE of vector 2.
    din_q.push_back(27'h1); din_q.push_back(27'h3);
    launch(3, 27'h1);
    cycles(5);
    abort = 1'b1;
    cycles(1);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_vec_cnt", vec_cnt, 1);
    check("abort_sig_hold", signature, 16'hFFFE);
    check("abort_dut_in_hold", dut_in, 27'h3);
    cycles(4);
    check("abort_stays_idle", busy, 0);

    // Start and abort together: abort wins.
    num_vec = CNT_W'(2); seed = 27'h1; start = 1'b1; abort = 1'b1;
    cycles(1);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_done", done, 0);
    check("start_abort_vec_hold", vec_cnt, 1);

    // Asynchronous reset mid-run, checked before the next clock edge.
    din_q.push_back(27'h1); din_q.push_back(27'h3);
    launch(3, 27'h1);
    cycles(5);
    #2 rst = 1'b1;
    #1 check_reset_values("async_reset");
    cycles(2);
    rst = 1'b0;
    cycles(2);

    check("exp_q_drained", exp_q.size(), 0);
    check("din_q_drained", din_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pla_vec_sequencer.md
Name: pla_vec_sequencer

Overview:
- Sequential stimulus/response harness for the flattened PLA benchmarks in the power-aware synthesis set (27-input / 6-output class).
- Generates input vectors with an LFSR and drives them into the benchmark inputs.
- After a settle window, samples the benchmark outputs, compacts them into a MISR signature and accumulates output toggle counts as a switching-activity proxy.
- Sits opposite the combinational benchmark: the benchmark consumes the vectors, and this block produces them and reads the results.

Parameters:
- IN_W, 27, benchmark input width (LFSR width fixed at 27; other values unsupported).
- OUT_W, 6, benchmark output width (must be ≤ 16).
- CNT_W, 16, width of vector count and toggle counter.
- SETTLE, 2, cycles between vector apply and output sample (≥ 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- abort  in  1  return to IDLE from any state; no done.
- num_vec  in  CNT_W  vectors per run; captured at start.
- seed  in  IN_W  LFSR seed; captured at start (0 is replaced by 1).
- dut_in  out  IN_W  registered vector to benchmark inputs.
- dut_out  in  OUT_W  benchmark outputs.
- busy  out  1  high in APPLY/SETTLE/SAMPLE.
- done  out  1  high in DONE; held until next start or abort.
- signature  out  16  MISR value.
- toggle_cnt  out  CNT_W  saturating output toggle count.
- vec_cnt  out  CNT_W  vectors sampled so far.

Behaviour:
- Reset values: dut_in=0, busy=0, done=0, signature=16'hFFFF, toggle_cnt=0, vec_cnt=0, FSM=IDLE. Reset may assert in any state and takes effect immediately.
- LFSR step: next = {lfsr[25:0], fb}, where fb = lfsr[26]^lfsr[4]^lfsr[1]^lfsr[0].
- MISR step: m' = {m[14:0], f} ^ zero_ext(dut_out), where f = m[15]^m[14]^m[12]^m[3].
- Toggle accumulation: toggle_cnt += popcount(dut_out ^ prev_out). The first sample of a run contributes 0. Saturates at 2^CNT_W-1.
- State IDLE/DONE, start=1:
  - If num_vec=0: go to DONE next cycle, with signature=FFFF, toggle_cnt=0, vec_cnt=0.
  - Otherwise: load dut_in=seed (or 1 if seed=0), set signature=FFFF, toggle_cnt=0, vec_cnt=0, go to APPLY.
- State APPLY: lasts 1 cycle, then SETTLE. dut_in is stable from APPLY through SAMPLE.
- State SETTLE: counts SETTLE cycles, then SAMPLE.
- State SAMPLE:
  - Updates the MISR, toggle_cnt and prev_out, and increments vec_cnt.
  - If vec_cnt+1 == num_vec: go to DONE.
  - Otherwise: dut_in=LFSR step, go to APPLY.
- Timing: per-vector period is SETTLE+2 cycles. With start sampled at cycle t, done rises at t+1+N*(SETTLE+2).
- start while busy: ignored.
- abort: has priority over start and all transitions. Next cycle FSM=IDLE, busy=0, done=0. Counters and signature hold their last values. dut_in holds.
- start and abort in the same cycle: abort wins.
- vec_cnt never wraps: bounded by num_vec.

Decomposition:
- Package pla_seq_pkg holds:
  - FSM state enum (IDLE, APPLY, SETTLE, SAMPLE, DONE).
  - LFSR tap constants (27,5,2,1).
  - MISR tap constants (16,15,13,4).
  - MISR init constant 16'hFFFF.
- One sub-module, pla_misr16: 16-bit MISR with init/enable/data inputs.
- The LFSR and toggle popcount stay inline.

Test Plan:
- Seed=1, N=3, SETTLE=2, dut_out=0 → dut_in sequence 27'h1, 27'h3, 27'h6; done rises 13 cycles after start; vec_cnt=3; toggle_cnt=0.
- Seed=1, N=1, dut_out=0 → signature=16'hFFFE; done rises at t+5.
- N=4, dut_out alternating 6'h3F/6'h00 per sample → toggle_cnt=18.
- N=0 → done high the next cycle, busy never high, signature=FFFF.
- Seed=0 → first dut_in=27'h1. start pulsed while busy → no restart; vec_cnt continues.
- abort in SETTLE of vector 2 → IDLE next cycle, done=0, vec_cnt=1. rst asserted mid-run → all outputs at reset values asynchronously.
